// File: rtl/even_odd_window_stats.sv
// -----------------------------------------------------------------------------
// even_odd_window_stats
//
// Purpose: counts even and odd 4-bit samples over fixed windows of WIN_LEN
// accepted samples. Each window result is presented with a sequence number.
// When the build enables the flag check, the block also counts samples whose
// upstream even/odd flags disagree with each other or with the data LSB.
//
// Optional feature: define EO_STATS_CHECK_EN to build the flag-consistency
// check. Without it, err_cnt is tied to 0 and no check logic exists.
//
// Handshake: a transfer happens on a rising clk edge where valid=1 and
// ready=1 on the same interface. in_ready is 1 only in ACCUM. out_valid is 1
// only in HOLD. Result outputs do not change while out_valid=1 and
// out_ready=0.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active high
//   in_valid   - upstream sample valid
//   in_ready   - block can accept a sample (0 while rst=1 and in HOLD)
//   data[3:0]  - sample; only data[0] decides even/odd
//   even, odd  - upstream detector flags (used only by the flag check)
//   out_valid  - window result presented
//   out_ready  - downstream accepts the result
//   even_cnt   - even samples in the window (saturating)
//   odd_cnt    - odd samples in the window (saturating)
//   err_cnt    - inconsistent-flag samples in the window (saturating)
//   win_id     - window sequence number, wraps modulo 16
// -----------------------------------------------------------------------------
module even_odd_window_stats #(
    parameter int WIN_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       data,
    input  logic             even,
    input  logic             odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       win_id
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(WIN_LEN - 1);

    state_t           state_q, state_d;
    logic [7:0]       smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] even_acc_q, even_acc_d;
    logic [CNT_W-1:0] odd_acc_q, odd_acc_d;
    logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
    logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
    logic [3:0]       win_id_q, win_id_d;

    logic             accept;
    logic [CNT_W-1:0] even_next;
    logic [CNT_W-1:0] odd_next;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // rst gates in_ready directly so nothing is offered while reset is held;
    // state_q is already ACCUM then, so in_ready rises right after release.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // Accumulator values including the current sample.
    assign even_next = data[0] ? even_acc_q : sat_inc(even_acc_q);
    assign odd_next  = data[0] ? sat_inc(odd_acc_q) : odd_acc_q;

`ifdef EO_STATS_CHECK_EN
    logic [CNT_W-1:0] err_acc_q, err_acc_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             flag_err;
    logic [CNT_W-1:0] err_next;
    logic             unused_hi;

    // A sample is suspect if both/neither flags are set, or the odd flag
    // disagrees with the LSB. Classification itself ignores the flags.
    assign flag_err  = (even == odd) || (odd != data[0]);
    assign err_next  = flag_err ? sat_inc(err_acc_q) : err_acc_q;
    assign unused_hi = ^data[3:1];
`else
    logic unused_in;
    assign unused_in = ^{data[3:1], even, odd};
`endif

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        even_acc_d = even_acc_q;
        odd_acc_d  = odd_acc_q;
        even_cnt_d = even_cnt_q;
        odd_cnt_d  = odd_cnt_q;
        win_id_d   = win_id_q;
`ifdef EO_STATS_CHECK_EN
        err_acc_d  = err_acc_q;
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    even_acc_d = even_next;
                    odd_acc_d  = odd_next;
`ifdef EO_STATS_CHECK_EN
                    err_acc_d  = err_next;
`endif
                    if (smp_cnt_q == LAST_IDX) begin
                        // Final sample: publish counts that include it.
                        state_d    = HOLD;
                        even_cnt_d = even_next;
                        odd_cnt_d  = odd_next;
`ifdef EO_STATS_CHECK_EN
                        err_cnt_d  = err_next;
`endif
                    end else begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = ACCUM;
                    smp_cnt_d  = '0;
                    even_acc_d = '0;
                    odd_acc_d  = '0;
`ifdef EO_STATS_CHECK_EN
                    err_acc_d  = '0;
`endif
                    win_id_d   = win_id_q + 4'd1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            smp_cnt_q  <= '0;
            even_acc_q <= '0;
            odd_acc_q  <= '0;
            even_cnt_q <= '0;
            odd_cnt_q  <= '0;
            win_id_q   <= '0;
`ifdef EO_STATS_CHECK_EN
            err_acc_q  <= '0;
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            even_acc_q <= even_acc_d;
            odd_acc_q  <= odd_acc_d;
            even_cnt_q <= even_cnt_d;
            odd_cnt_q  <= odd_cnt_d;
            win_id_q   <= win_id_d;
`ifdef EO_STATS_CHECK_EN
            err_acc_q  <= err_acc_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign even_cnt = even_cnt_q;
    assign odd_cnt  = odd_cnt_q;
    assign win_id   = win_id_q;
`ifdef EO_STATS_CHECK_EN
    assign err_cnt  = err_cnt_q;
`else
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_even_odd_window_stats.sv
// -----------------------------------------------------------------------------
// Bench for even_odd_window_stats. Main instance uses WIN_LEN=4, CNT_W=8; a
// second small instance (WIN_LEN=5, CNT_W=2) exercises saturation.
// A negedge reference model tracks windows as sample lists and derives the
// expected counts, hold state and window number from them.
// -----------------------------------------------------------------------------
module tb_even_odd_window_stats;

    localparam int WL = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data;
    logic       even;
    logic       odd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] even_cnt;
    logic [7:0] odd_cnt;
    logic [7:0] err_cnt;
    logic [3:0] win_id;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [3:0] s_data;
    logic       s_even;
    logic       s_odd;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [1:0] s_even_cnt;
    logic [1:0] s_odd_cnt;
    logic [1:0] s_err_cnt;
    logic [3:0] s_win_id;

    even_odd_window_stats #(.WIN_LEN(WL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .even(even), .odd(odd),
        .out_valid(out_valid), .out_ready(out_ready),
        .even_cnt(even_cnt), .odd_cnt(odd_cnt), .err_cnt(err_cnt),
        .win_id(win_id)
    );

    even_odd_window_stats #(.WIN_LEN(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .data(s_data), .even(s_even), .odd(s_odd),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .even_cnt(s_even_cnt), .odd_cnt(s_odd_cnt), .err_cnt(s_err_cnt),
        .win_id(s_win_id)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [5:0]  win_smp[$];   // {odd, even, data}
    logic [27:0] exp_q[$];     // {win, err, odd, even}
    logic        exp_hold = 1'b0;
    logic [3:0]  win_model = 4'd0;

    function automatic logic [27:0] window_result(input logic [3:0] w);
        int ev = 0;
        int od = 0;
        int er = 0;
        foreach (win_smp[i]) begin
            if (win_smp[i][0]) od++;
            else ev++;
            if ((win_smp[i][4] == win_smp[i][5]) || (win_smp[i][5] != win_smp[i][0])) er++;
        end
`ifndef EO_STATS_CHECK_EN
        er = 0;
`endif
        return {w, 8'(er), 8'(od), 8'(ev)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_even_cnt", even_cnt, 0);
            chk("rst_odd_cnt", odd_cnt, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_win_id", win_id, 0);
            chk("rst_s_in_ready", s_in_ready, 0);
            chk("rst_s_even_cnt", s_even_cnt, 0);
            win_smp.delete();
            exp_q.delete();
            exp_hold = 1'b0;
            win_model = 4'd0;
        end else begin
            chk("in_ready", in_ready, !exp_hold);
            chk("out_valid", out_valid, exp_hold);
            if (exp_hold) begin
                logic [27:0] e;
                e = exp_q[0];
                chk("even_cnt", even_cnt, e[7:0]);
                chk("odd_cnt", odd_cnt, e[15:8]);
                chk("err_cnt", err_cnt, e[23:16]);
                chk("win_id", win_id, e[27:24]);
                chk("cnt_sum", even_cnt + odd_cnt, WL);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    exp_hold = 1'b0;
                    win_model = win_model + 4'd1;
                end
            end else if (in_valid) begin
                win_smp.push_back({odd, even, data});
                if (win_smp.size() == WL) begin
                    exp_q.push_back(window_result(win_model));
                    win_smp.delete();
                    exp_hold = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] d, input logic e, input logic o);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        data = d;
        even = e;
        odd = o;
        for (int t = 0; t < 100 && !done; t++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = in_ready;
            step();
        end
        if (!done) chk("feed_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic feed_ok(input logic [3:0] d);
        feed(d, ~d[0], d[0]);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; data = '0; even = 1'b0; odd = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_data = '0; s_even = 1'b0; s_odd = 1'b0; s_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        step();

        // Basic window: 4,5,6,7 back to back.
        out_ready = 1'b1;
        feed_ok(4'd4); feed_ok(4'd5); feed_ok(4'd6); feed_ok(4'd7);
        @(negedge clk);
        chk("w0_valid", out_valid, 1);
        chk("w0_even", even_cnt, 2);
        chk("w0_odd", odd_cnt, 2);
        chk("w0_err", err_cnt, 0);
        chk("w0_id", win_id, 0);
        step();
        @(negedge clk);
        chk("w0_one_cycle", out_valid, 0);
        step();
        feed_ok(4'd0); feed_ok(4'd1); feed_ok(4'd2); feed_ok(4'd3);
        @(negedge clk);
        chk("w1_id", win_id, 1);
        step();

        // Backpressure with a sample 2 offered during HOLD.
        out_ready = 1'b0;
        feed_ok(4'd1); feed_ok(4'd3); feed_ok(4'd5); feed_ok(4'd8);
        in_valid = 1'b1; data = 4'd2; even = 1'b1; odd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_even", even_cnt, 1);
            chk("bp_odd", odd_cnt, 3);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_in_ready", in_ready, 0);
        step();
        @(negedge clk);
        chk("bp_after_hs_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        feed_ok(4'd4); feed_ok(4'd6); feed_ok(4'd8);
        @(negedge clk);
        chk("bp_next_even", even_cnt, 4);
        chk("bp_next_odd", odd_cnt, 0);
        step();

        // Flag check: one sample with both flags set.
        feed(4'd2, 1'b1, 1'b1);
        feed_ok(4'd3); feed_ok(4'd4); feed_ok(4'd5);
        @(negedge clk);
`ifdef EO_STATS_CHECK_EN
        chk("flag_err", err_cnt, 1);
`else
        chk("flag_err", err_cnt, 0);
`endif
        chk("flag_even", even_cnt, 2);
        step();

        // Reset mid-window discards the partial window.
        feed_ok(4'd1); feed_ok(4'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", in_ready, 0);
        step();
        rst = 1'b0;
        feed_ok(4'd4); feed_ok(4'd4); feed_ok(4'd4); feed_ok(4'd4);
        @(negedge clk);
        chk("mid_rst_even", even_cnt, 4);
        chk("mid_rst_odd", odd_cnt, 0);
        chk("mid_rst_id", win_id, 0);
        step();

        // Reset during HOLD drops the pending result.
        out_ready = 1'b0;
        feed_ok(4'd1); feed_ok(4'd2); feed_ok(4'd3); feed_ok(4'd4);
        @(negedge clk);
        chk("hold_rst_pre", out_valid, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("hold_rst_valid", out_valid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("hold_rst_after", out_valid, 0);
        chk("hold_rst_id", win_id, 0);
        step();

        // 17 random windows with gaps and random out_ready.
        rand_ready = 1'b1;
        for (int w = 0; w < 17; w++) begin
            for (int i = 0; i < WL; i++) begin
                logic [3:0] d;
                repeat ($urandom_range(0, 2)) step();
                d = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0)
                    feed(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    feed_ok(d);
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("wrap_id", win_id, 1);
        step();

        // Saturation on the CNT_W=2 instance: five evens saturate at 3.
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1; s_data = 4'd6; s_even = 1'b1; s_odd = 1'b0;
            @(negedge clk);
            chk("sat_in_ready", s_in_ready, 1);
            step();
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("sat_valid", s_out_valid, 1);
        chk("sat_even", s_even_cnt, 3);
        chk("sat_odd", s_odd_cnt, 0);
        chk("sat_err", s_err_cnt, 0);
        step();
        s_out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("sat_release", s_out_valid, 0);
        chk("sat_id", s_win_id, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
